// File: rtl/instruction_fetch.sv
// Instruction fetch stage: issues single-outstanding word reads to instruction
// memory, queues returned words with their addresses for decode, and computes
// the next PC value that the PC register loads every clock.
//
// state  | meaning
// -------+---------------------------------------------------
// S_IDLE | no memory request outstanding
// S_WAIT | request outstanding, response will be queued
// S_KILL | request outstanding, response will be dropped
module instruction_fetch #(
   parameter int DEPTH = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] pc_current,
   output logic [31:0] pc_next,
   input  logic        redirect,
   input  logic [31:0] redirect_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        ins_valid,
   input  logic        ins_ready,
   output logic [31:0] ins_word,
   output logic [31:0] ins_pc
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_KILL
   } state_t;

   state_t        state;
   logic [31:0]   q_word [DEPTH];
   logic [31:0]   q_pc   [DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] count;
   logic [CW-1:0] count_n;
   logic          push;
   logic          pop;
   logic          issue;

   assign ins_valid = (count != '0);
   assign ins_word  = q_word[head];
   assign ins_pc    = q_pc[head];

   // Handshake decode; a new issue must leave room for its own response.
   always_comb begin
      push    = (state == S_WAIT) && imem_ack && !redirect;
      pop     = ins_valid && ins_ready;
      count_n = count + CW'(push) - CW'(pop);
      issue   = ((state == S_IDLE) || ((state == S_WAIT) && imem_ack))
                && !redirect && (count_n < CW'(DEPTH));
   end

   // Next PC: redirect wins, otherwise advance only when a fetch is issued.
   always_comb begin
      pc_next = pc_current;
      if (reset) begin
         pc_next = 32'd0;
      end else if (redirect) begin
         pc_next = redirect_target;
      end else if (issue) begin
         pc_next = pc_current + 32'd4;
      end
   end

   // Request FSM with registered bus outputs; address is held while a request is open.
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= S_IDLE;
         imem_req  <= 1'b0;
         imem_addr <= 32'd0;
      end else if (issue) begin
         state     <= S_WAIT;
         imem_req  <= 1'b1;
         imem_addr <= pc_current;
      end else begin
         case (state)
            S_IDLE: begin
               imem_req <= 1'b0;
            end
            S_WAIT: begin
               if (imem_ack) begin
                  state    <= S_IDLE;
                  imem_req <= 1'b0;
               end else if (redirect) begin
                  state <= S_KILL;
               end
            end
            S_KILL: begin
               if (imem_ack) begin
                  state    <= S_IDLE;
                  imem_req <= 1'b0;
               end
            end
            default: begin
               state    <= S_IDLE;
               imem_req <= 1'b0;
            end
         endcase
      end
   end

   // Queue pointers and occupancy; a redirect empties the queue outright.
   always_ff @(posedge clock) begin
      if (reset || redirect) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            tail <= tail + PW'(1);
         end
         if (pop) begin
            head <= head + PW'(1);
         end
         count <= count_n;
      end
   end

   // Queue storage, written at the tail with the address the word was fetched from.
   always_ff @(posedge clock) begin
      if (push) begin
         q_word[tail] <= imem_rdata;
         q_pc[tail]   <= imem_addr;
      end
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: a behavioural PC register and instruction memory
// with programmable ack latency surround the DUT; expected fetch addresses are
// queued by the stimulus and checked by an independent decode-side monitor.
module tb_instruction_fetch;

   localparam int DEPTH = 2;

   logic        clock;
   logic        reset;
   logic [31:0] pc_current;
   logic [31:0] pc_next;
   logic        redirect;
   logic [31:0] redirect_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        ins_valid;
   logic        ins_ready;
   logic [31:0] ins_word;
   logic [31:0] ins_pc;

   int          n_vec;
   int          n_err;
   int          cyc;
   int          lat;
   logic        hold_ready;
   logic        ack_force;
   logic [31:0] exp_q[$];
   logic [31:0] mon_e;

   instruction_fetch #(.DEPTH(DEPTH)) dut (
      .clock           (clock),
      .reset           (reset),
      .pc_current      (pc_current),
      .pc_next         (pc_next),
      .redirect        (redirect),
      .redirect_target (redirect_target),
      .imem_req        (imem_req),
      .imem_addr       (imem_addr),
      .imem_ack        (imem_ack),
      .imem_rdata      (imem_rdata),
      .ins_valid       (ins_valid),
      .ins_ready       (ins_ready),
      .ins_word        (ins_word),
      .ins_pc          (ins_pc)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      n_vec++;
      if (act !== want) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, want, cyc);
      end
   endtask

   // PC register: loads pc_next every clock
   always @(posedge clock) pc_current <= pc_next;

   // cycle number relative to reset release
   always @(posedge clock) cyc <= reset ? 0 : cyc + 1;

   // instruction memory: ack after lat extra cycles of a request
   initial begin
      int   cnt;
      logic prev_req;
      logic prev_ack;
      logic ack;
      cnt        = 0;
      prev_req   = 1'b0;
      prev_ack   = 1'b0;
      imem_ack   = 1'b0;
      imem_rdata = 32'd0;
      forever begin
         @(posedge clock);
         #1;
         if (imem_req) begin
            if (!prev_req || prev_ack) cnt = 0;
            else cnt = cnt + 1;
            ack = (cnt == lat);
         end else begin
            cnt = 0;
            ack = 1'b0;
         end
         imem_ack   = ack || ack_force;
         imem_rdata = mem_word(imem_addr);
         prev_req   = imem_req;
         prev_ack   = imem_ack;
      end
   end

   // decode accepts only while an expectation is pending and not stalled
   initial begin
      ins_ready = 1'b0;
      forever begin
         @(posedge clock);
         #2;
         ins_ready = !hold_ready && (exp_q.size() != 0);
      end
   end

   // scoreboard monitor: compares every accepted instruction
   initial begin
      forever begin
         @(negedge clock);
         if (!reset && ins_valid && ins_ready) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_pop: got pc 0x%08h, want no instruction (cycle %0d)", ins_pc, cyc);
            end else begin
               mon_e = exp_q.pop_front();
               chk("pop_pc", ins_pc, mon_e);
               chk("pop_word", ins_word, mem_word(mon_e));
            end
         end
      end
   end

   task automatic at_cycle(input int k);
      int g;
      g = 0;
      while (cyc < k && g < 500) begin
         @(negedge clock);
         g++;
      end
      if (cyc != k) begin
         n_vec++;
         n_err++;
         $display("FAIL at_cycle: got cycle %0d, want %0d", cyc, k);
      end
   endtask

   task automatic do_reset(input int latency, input logic hold);
      @(negedge clock);
      reset      = 1'b1;
      redirect   = 1'b0;
      ack_force  = 1'b0;
      lat        = latency;
      hold_ready = hold;
      exp_q.delete();
      @(negedge clock);
      @(negedge clock);
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_addr", imem_addr, 32'd0);
      chk("rst_valid", {31'd0, ins_valid}, 32'd0);
      chk("rst_pc_next", pc_next, 32'd0);
      reset = 1'b0;
      #1;
   endtask

   task automatic end_test();
      int g;
      g = 0;
      while (exp_q.size() != 0 && g < 60) begin
         @(negedge clock);
         g++;
      end
      chk("drain_left", 32'(exp_q.size()), 32'd0);
      @(negedge clock);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      n_vec           = 0;
      n_err           = 0;
      reset           = 1'b1;
      redirect        = 1'b0;
      redirect_target = 32'd0;
      hold_ready      = 1'b1;
      ack_force       = 1'b0;
      lat             = 0;

      // zero-wait memory, decode always ready: one word per cycle
      do_reset(0, 1'b0);
      exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
      at_cycle(0);
      chk("t1_c0_pc_next", pc_next, 32'h4);
      chk("t1_c0_req", {31'd0, imem_req}, 32'd0);
      at_cycle(1);
      chk("t1_c1_req", {31'd0, imem_req}, 32'd1);
      chk("t1_c1_addr", imem_addr, 32'h0);
      chk("t1_c1_valid", {31'd0, ins_valid}, 32'd0);
      chk("t1_c1_pc", pc_current, 32'h4);
      for (int i = 2; i <= 5; i++) begin
         at_cycle(i);
         chk("t1_valid", {31'd0, ins_valid}, 32'd1);
         chk("t1_ins_pc", ins_pc, 32'((i - 2) * 4));
         chk("t1_req", {31'd0, imem_req}, 32'd1);
      end
      end_test();

      // memory acks in the fourth cycle of each request
      do_reset(3, 1'b0);
      exp_q = '{32'h0, 32'h4, 32'h8};
      at_cycle(3);
      chk("t2_c3_req", {31'd0, imem_req}, 32'd1);
      chk("t2_c3_addr", imem_addr, 32'h0);
      chk("t2_c3_valid", {31'd0, ins_valid}, 32'd0);
      at_cycle(4);
      chk("t2_c4_addr", imem_addr, 32'h0);
      at_cycle(5);
      chk("t2_c5_valid", {31'd0, ins_valid}, 32'd1);
      chk("t2_c5_ins_pc", ins_pc, 32'h0);
      chk("t2_c5_addr", imem_addr, 32'h4);
      at_cycle(6);
      chk("t2_c6_valid", {31'd0, ins_valid}, 32'd0);
      at_cycle(8);
      chk("t2_c8_valid", {31'd0, ins_valid}, 32'd0);
      at_cycle(9);
      chk("t2_c9_ins_pc", ins_pc, 32'h4);
      at_cycle(13);
      chk("t2_c13_ins_pc", ins_pc, 32'h8);
      end_test();

      // decode stalled: queue fills to DEPTH, requests stop, then resume
      do_reset(0, 1'b1);
      exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
      at_cycle(3);
      chk("t3_c3_req", {31'd0, imem_req}, 32'd0);
      chk("t3_c3_valid", {31'd0, ins_valid}, 32'd1);
      chk("t3_c3_ins_pc", ins_pc, 32'h0);
      chk("t3_c3_word", ins_word, 32'hC0DE_0000);
      chk("t3_c3_pc", pc_current, 32'h8);
      chk("t3_c3_pc_next", pc_next, 32'h8);
      at_cycle(5);
      chk("t3_c5_req", {31'd0, imem_req}, 32'd0);
      chk("t3_c5_pc", pc_current, 32'h8);
      hold_ready = 1'b0;
      at_cycle(7);
      chk("t3_c7_req", {31'd0, imem_req}, 32'd1);
      chk("t3_c7_addr", imem_addr, 32'h8);
      chk("t3_c7_ins_pc", ins_pc, 32'h4);
      at_cycle(9);
      chk("t3_c9_ins_pc", ins_pc, 32'hC);
      end_test();

      // redirect while a request is outstanding: stale word dropped
      do_reset(2, 1'b1);
      exp_q = '{32'h100};
      at_cycle(4);
      chk("t4_c4_valid", {31'd0, ins_valid}, 32'd1);
      chk("t4_c4_ins_pc", ins_pc, 32'h0);
      chk("t4_c4_addr", imem_addr, 32'h4);
      at_cycle(5);
      redirect        = 1'b1;
      redirect_target = 32'h100;
      hold_ready      = 1'b0;
      at_cycle(6);
      redirect = 1'b0;
      chk("t4_c6_valid", {31'd0, ins_valid}, 32'd0);
      chk("t4_c6_req", {31'd0, imem_req}, 32'd1);
      chk("t4_c6_addr", imem_addr, 32'h4);
      chk("t4_c6_pc", pc_current, 32'h100);
      at_cycle(8);
      chk("t4_c8_req", {31'd0, imem_req}, 32'd1);
      chk("t4_c8_addr", imem_addr, 32'h100);
      at_cycle(11);
      chk("t4_c11_valid", {31'd0, ins_valid}, 32'd1);
      chk("t4_c11_ins_pc", ins_pc, 32'h100);
      end_test();

      // redirect coincident with an ack
      do_reset(0, 1'b1);
      exp_q = '{32'h200};
      at_cycle(2);
      redirect        = 1'b1;
      redirect_target = 32'h200;
      hold_ready      = 1'b0;
      at_cycle(3);
      redirect = 1'b0;
      chk("t5a_c3_valid", {31'd0, ins_valid}, 32'd0);
      chk("t5a_c3_req", {31'd0, imem_req}, 32'd0);
      chk("t5a_c3_pc", pc_current, 32'h200);
      at_cycle(4);
      chk("t5a_c4_addr", imem_addr, 32'h200);
      at_cycle(5);
      chk("t5a_c5_valid", {31'd0, ins_valid}, 32'd1);
      chk("t5a_c5_ins_pc", ins_pc, 32'h200);
      end_test();

      // redirect coincident with a pop, request still waiting
      do_reset(1, 1'b0);
      exp_q = '{32'h0, 32'h300};
      at_cycle(3);
      chk("t5b_c3_valid", {31'd0, ins_valid}, 32'd1);
      chk("t5b_c3_ins_pc", ins_pc, 32'h0);
      redirect        = 1'b1;
      redirect_target = 32'h300;
      at_cycle(4);
      redirect = 1'b0;
      chk("t5b_c4_valid", {31'd0, ins_valid}, 32'd0);
      chk("t5b_c4_req", {31'd0, imem_req}, 32'd1);
      chk("t5b_c4_addr", imem_addr, 32'h4);
      at_cycle(6);
      chk("t5b_c6_addr", imem_addr, 32'h300);
      at_cycle(8);
      chk("t5b_c8_ins_pc", ins_pc, 32'h300);
      end_test();

      // PC wraps from the top of the address space
      do_reset(0, 1'b0);
      exp_q = '{32'hFFFF_FFFC, 32'h0};
      at_cycle(0);
      redirect        = 1'b1;
      redirect_target = 32'hFFFF_FFFC;
      at_cycle(1);
      redirect = 1'b0;
      chk("t6_c1_req", {31'd0, imem_req}, 32'd0);
      chk("t6_c1_pc", pc_current, 32'hFFFF_FFFC);
      #1;
      chk("t6_c1_pc_next", pc_next, 32'h0);
      at_cycle(2);
      chk("t6_c2_addr", imem_addr, 32'hFFFF_FFFC);
      at_cycle(3);
      chk("t6_c3_ins_pc", ins_pc, 32'hFFFF_FFFC);
      at_cycle(4);
      chk("t6_c4_ins_pc", ins_pc, 32'h0);
      end_test();

      // reset while waiting, then a stray ack arrives after reset
      do_reset(5, 1'b0);
      at_cycle(2);
      chk("t7_pre_req", {31'd0, imem_req}, 32'd1);
      reset     = 1'b1;
      ack_force = 1'b1;
      @(negedge clock);
      reset     = 1'b0;
      ack_force = 1'b0;
      chk("t7_rst_req", {31'd0, imem_req}, 32'd0);
      chk("t7_rst_valid", {31'd0, ins_valid}, 32'd0);
      @(negedge clock);
      chk("t7_post_valid", {31'd0, ins_valid}, 32'd0);
      chk("t7_post_req", {31'd0, imem_req}, 32'd1);
      chk("t7_post_addr", imem_addr, 32'h0);
      end_test();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
